// File: rtl/frame_buffer.sv
// frame_buffer: 128x256 (32768 x 6-bit) single-port pixel RAM shared between
// the VGA display read path, a full-frame clear engine and a 4-entry pixel
// write FIFO. Port priority per cycle: display read > clear write > FIFO write.
module frame_buffer (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hor_addr,
    input  logic [7:0] ver_addr,
    input  logic       read,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_x,
    input  logic [7:0] wr_y,
    input  logic [5:0] wr_color,
    input  logic       clear,
    output logic       busy,
    output logic [5:0] data
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Pixels outside the visible/addressable window are dropped: rows past
    // 149 and the unused column band 23..49.
    function automatic logic is_discarded(input logic [7:0] y, input logic [6:0] x);
        is_discarded = (y >= 8'd150) || ((x >= 7'd23) && (x <= 7'd49));
    endfunction

    state_t      state_r;
    logic [14:0] clr_cnt_r;
    logic        busy_r;
    logic [5:0]  data_r;

    logic [20:0] fifo_mem_r [0:3];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;

    logic [5:0]  ram_r [0:32767];

    logic        push_s;
    logic        pop_s;
    logic [20:0] head_s;
    logic        ram_we_s;
    logic [14:0] ram_addr_s;
    logic [5:0]  ram_wdata_s;

    assign wr_ready = (count_r < 3'd4);
    assign busy     = busy_r;
    assign data     = data_r;

    assign push_s = wr_valid && (count_r < 3'd4);
    assign pop_s  = !read && (state_r == IDLE) && (count_r != 3'd0);
    assign head_s = fifo_mem_r[rd_ptr_r];

    // RAM port arbitration: display read wins, then clear, then FIFO head.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_addr_s  = {ver_addr, hor_addr};
        ram_wdata_s = 6'd0;
        if (rst) begin
            ram_we_s = 1'b0;
        end else if (read) begin
            ram_we_s = 1'b0;
        end else begin
            case (state_r)
                CLEAR: begin
                    ram_we_s    = 1'b1;
                    ram_addr_s  = clr_cnt_r;
                    ram_wdata_s = 6'd0;
                end
                IDLE: begin
                    if (pop_s && !is_discarded(head_s[20:13], head_s[12:6])) begin
                        ram_we_s    = 1'b1;
                        ram_addr_s  = {head_s[20:13], head_s[12:6]};
                        ram_wdata_s = head_s[5:0];
                    end else begin
                        ram_we_s = 1'b0;
                    end
                end
                default: begin
                    ram_we_s = 1'b0;
                end
            endcase
        end
    end

    // Pixel RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[ram_addr_s] <= ram_wdata_s;
        end
    end

    // Display read register: one-cycle latency, holds value outside the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= 6'd0;
        end else if (read) begin
            data_r <= ram_r[ram_addr_s];
        end
    end

    // FIFO storage, written on every accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {wr_y, wr_x, wr_color};
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Clear FSM: walks every address once, stalling while the display reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            clr_cnt_r <= 15'd0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (clear) begin
                        state_r   <= CLEAR;
                        clr_cnt_r <= 15'd0;
                        busy_r    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (!read) begin
                        clr_cnt_r <= clr_cnt_r + 15'd1;
                        if (clr_cnt_r == 15'h7FFF) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= CLEAR;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    clr_cnt_r <= 15'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer: table of pixel writes with expected
// read-back values, plus hand-written sequences for FIFO back-pressure,
// discard filtering, full-frame clears and reset in mid-operation.
module tb_frame_buffer;

    logic       clk;
    logic       rst;
    logic [6:0] hor_addr;
    logic [7:0] ver_addr;
    logic       read;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_x;
    logic [7:0] wr_y;
    logic [5:0] wr_color;
    logic       clear;
    logic       busy;
    logic [5:0] data;

    int total;
    int bad;

    typedef struct {
        logic [6:0] x;
        logic [7:0] y;
        logic [5:0] c;
        logic [5:0] exp;
    } vec_t;

    vec_t vt [12];

    frame_buffer dut (
        .clk      (clk),
        .rst      (rst),
        .hor_addr (hor_addr),
        .ver_addr (ver_addr),
        .read     (read),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_color (wr_color),
        .clear    (clear),
        .busy     (busy),
        .data     (data)
    );

    // 50 MHz clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] x, input logic [7:0] y, input logic [5:0] c);
        wr_x     = x;
        wr_y     = y;
        wr_color = c;
        wr_valid = 1'b1;
        chk("push_ready", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic readpix(input logic [6:0] x, input logic [7:0] y, output logic [5:0] d);
        read     = 1'b1;
        hor_addr = x;
        ver_addr = y;
        step();
        d    = data;
        read = 1'b0;
    endtask

    task automatic chkpix(input string name, input logic [6:0] x, input logic [7:0] y,
                          input logic [5:0] exp);
        logic [5:0] d;
        readpix(x, y, d);
        chk(name, 32'(d), 32'(exp));
    endtask

    // Proves the FIFO is empty: exactly four pushes fit while reads block pops.
    task automatic verify_empty(input string tag);
        read = 1'b1;
        for (int i = 0; i < 4; i++) push(7'd40, 8'd0, 6'h3F);
        chk({tag, "_full"}, 32'(wr_ready), 32'd0);
        read = 1'b0;
        steps(4);
        chk({tag, "_drained"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        int n;
        logic [14:0] a;
        logic [5:0] d;

        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        hor_addr = 7'd0;
        ver_addr = 8'd0;
        read     = 1'b0;
        wr_valid = 1'b0;
        wr_x     = 7'd0;
        wr_y     = 8'd0;
        wr_color = 6'd0;
        clear    = 1'b0;

        vt[0]  = '{7'd60,  8'd10,  6'h2A, 6'h2A};
        vt[1]  = '{7'd0,   8'd0,   6'h3F, 6'h3F};
        vt[2]  = '{7'd127, 8'd149, 6'h15, 6'h15};
        vt[3]  = '{7'd22,  8'd1,   6'h01, 6'h01};
        vt[4]  = '{7'd23,  8'd1,   6'h02, 6'h00};
        vt[5]  = '{7'd49,  8'd1,   6'h03, 6'h00};
        vt[6]  = '{7'd50,  8'd1,   6'h04, 6'h04};
        vt[7]  = '{7'd10,  8'd149, 6'h05, 6'h05};
        vt[8]  = '{7'd10,  8'd150, 6'h06, 6'h00};
        vt[9]  = '{7'd10,  8'd255, 6'h07, 6'h00};
        vt[10] = '{7'd5,   8'd2,   6'h2B, 6'h2B};
        vt[11] = '{7'd10,  8'd100, 6'h1C, 6'h1C};

        // reset state
        steps(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd1);
        chk("rst_data", 32'(data), 32'd0);
        rst = 1'b0;
        step();

        // seed some non-zero pixels, then clear with read held low
        push(7'd0, 8'd0, 6'h11);
        push(7'd127, 8'd149, 6'h22);
        push(7'd5, 8'd2, 6'h33);
        steps(2);
        chkpix("seed_pix", 7'd5, 8'd2, 6'h33);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40000) begin
            n++;
            step();
        end
        chk("clear_busy_len", 32'(n), 32'd32768);
        for (int i = 0; i < 64; i++) begin
            a = 15'(i * 512 + 257);
            chkpix("clear_scan", a[6:0], a[14:7], 6'h00);
        end
        chkpix("clear_first", 7'd0, 8'd0, 6'h00);
        chkpix("clear_last", 7'd127, 8'd255, 6'h00);
        chkpix("clear_seed", 7'd127, 8'd149, 6'h00);

        // table-driven pixel writes and read-back
        for (int i = 0; i < 12; i++) push(vt[i].x, vt[i].y, vt[i].c);
        steps(2);
        for (int i = 0; i < 12; i++) chkpix($sformatf("vec%0d", i), vt[i].x, vt[i].y, vt[i].exp);

        // data holds while read is low
        hor_addr = 7'd0;
        ver_addr = 8'd0;
        steps(2);
        chk("data_hold", 32'(data), 32'h1C);

        // back-pressure with read held high, then ordered drain
        read     = 1'b1;
        hor_addr = 7'd0;
        ver_addr = 8'd0;
        for (int i = 0; i < 5; i++) begin
            wr_x     = (i == 2) ? 7'd71 : 7'd70;
            wr_y     = 8'd20;
            wr_color = 6'(i + 1);
            wr_valid = 1'b1;
            chk($sformatf("bp_ready%0d", i), 32'(wr_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        wr_valid = 1'b0;
        chk("bp_full", 32'(wr_ready), 32'd0);
        read = 1'b0;
        step();
        chk("bp_one_pop", 32'(wr_ready), 32'd1);
        step();
        read     = 1'b1;
        hor_addr = 7'd70;
        ver_addr = 8'd20;
        step();
        chk("bp_two_written", 32'(data), 32'h02);
        read = 1'b0;
        steps(2);
        chkpix("bp_final_p", 7'd70, 8'd20, 6'h04);
        chkpix("bp_final_q", 7'd71, 8'd20, 6'h03);
        verify_empty("bp_empty");

        // discarded entries
        push(7'd30, 8'd5, 6'h3C);
        push(7'd60, 8'd200, 6'h3D);
        steps(3);
        chkpix("disc_col", 7'd30, 8'd5, 6'h00);
        chkpix("disc_row", 7'd60, 8'd200, 6'h00);
        verify_empty("disc_empty");

        // reset in the middle of a clear with three pending entries
        chkpix("pre_rst_data", 7'd10, 8'd100, 6'h1C);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("rc_busy", 32'(busy), 32'd1);
        push(7'd80, 8'd30, 6'h11);
        push(7'd81, 8'd30, 6'h12);
        push(7'd82, 8'd30, 6'h13);
        steps(997);
        chk("rc_busy_pre", 32'(busy), 32'd1);
        chk("rc_ready_pre", 32'(wr_ready), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rc_busy_post", 32'(busy), 32'd0);
        chk("rc_ready_post", 32'(wr_ready), 32'd1);
        chk("rc_data_post", 32'(data), 32'd0);
        step();
        chk("rc_busy_stays", 32'(busy), 32'd0);
        verify_empty("rc_empty");
        chkpix("rc_pend0", 7'd80, 8'd30, 6'h00);
        chkpix("rc_pend2", 7'd82, 8'd30, 6'h00);
        chkpix("rc_low_cleared", 7'd5, 8'd2, 6'h00);
        chkpix("rc_mid_kept", 7'd60, 8'd10, 6'h2A);
        chkpix("rc_high_kept", 7'd10, 8'd100, 6'h1C);

        // clear with read toggling every cycle, second pulse mid-way ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 70000) begin
            read  = ~read;
            clear = (n == 30000) ? 1'b1 : 1'b0;
            n++;
            step();
        end
        read  = 1'b0;
        clear = 1'b0;
        chk("toggle_busy_len_ok", 32'((n >= 65534) && (n <= 65538)), 32'd1);
        chkpix("toggle_cleared_a", 7'd10, 8'd100, 6'h00);
        chkpix("toggle_cleared_b", 7'd60, 8'd10, 6'h00);
        chk("toggle_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer.md
FRAME_BUFFER -- requirements
Module: frame_buffer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, named as the codebase does: clk and rst.
REQ-002 clk  input  1  50 MHz system clock, same clock as the VGA timing block.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 hor_addr  input  7  pixel column address from the VGA timing block.
REQ-005 ver_addr  input  8  pixel row address from the VGA timing block.
REQ-006 read  input  1  VGA visible window; RAM port is owned by the display while high.
REQ-007 wr_valid  input  1  pixel-write request valid.
REQ-008 wr_ready  output  1  request accepted when wr_valid and wr_ready are both high.
REQ-009 wr_x  input  7  target column; wr_y  input  8  target row; wr_color  input  6  RGB 2:2:2 pixel.
REQ-010 clear  input  1  single-cycle pulse that starts a full-frame clear to 6'd0.
REQ-011 busy  output  1  high while a clear is in progress.
REQ-012 data  output  6  pixel to the VGA block, with bit order identical to wr_color.

Function
REQ-013 SHALL hold one single-port RAM of 32768 x 6 bits, with address {row[7:0], col[6:0]}.
REQ-014 Port arbitration SHALL be fixed priority per cycle: display read (read=1) > clear write > FIFO write.
REQ-015 While read=1, the block SHALL register data <= RAM[{ver_addr,hor_addr}], giving data one cycle after the address.
REQ-016 While read=0, data SHALL hold its last value.
REQ-017 The write FIFO SHALL be 4 entries deep and 21 bits wide ({y,x,color}), first-in first-out.
REQ-018 wr_ready SHALL equal (count<4), driven combinationally from registered count.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged and keep ordering.
REQ-020 A pop SHALL occur only when read=0, state=IDLE and count>0; the popped entry is written that cycle.
REQ-021 Entries with wr_y>=150, or with wr_x in 23..49, SHALL be popped and discarded without a RAM write.
REQ-022 The FSM SHALL have exactly two states, IDLE and CLEAR.
REQ-023 IDLE->CLEAR SHALL occur on clear=1; the 15-bit clear counter loads 0 on entry.
REQ-024 In CLEAR, on each read=0 cycle, the block SHALL write 0 to RAM[clr_cnt] and increment clr_cnt; on read=1 cycles the counter stalls.
REQ-025 CLEAR->IDLE SHALL occur in the cycle that writes address 32767.
REQ-026 clear pulses while in CLEAR SHALL be ignored and shall not restart the clear.
REQ-027 busy SHALL be 1 exactly in state CLEAR.
REQ-028 During CLEAR, the FIFO SHALL still accept pushes up to full, but shall not pop.
REQ-029 The FIFO pointers SHALL be 2 bits and wrap modulo 4; count SHALL be 3 bits (0..4).

Reset
REQ-030 On rst, the block SHALL set: state=IDLE, clr_cnt=0, FIFO pointers and count=0, data=6'd0, busy=0, wr_ready=1.
REQ-031 RAM contents SHALL NOT be reset; software clears the frame with the clear input.
REQ-032 rst asserted mid-CLEAR or with a non-empty FIFO SHALL abort the operation and discard pending entries; no RAM write occurs in the reset cycle.

Verification
REQ-033 Bench SHALL cover: push (x=60,y=10,c=6'h2A) with read=0, then read=1 at hor_addr=60, ver_addr=10 -> data=6'h2A one cycle later.
REQ-034 Bench SHALL cover: hold read=1 and push 5 requests back-to-back -> wr_ready drops after the 4th; after read falls, the 4 entries are written in order, one per cycle.
REQ-035 Bench SHALL cover: push (x=30,y=5) and (x=60,y=200) -> both popped with no RAM change; count returns to 0.
REQ-036 Bench SHALL cover: clear pulse with read=0 constant -> busy=1 for exactly 32768 cycles, after which every address reads 0.
REQ-037 Bench SHALL cover: clear with read toggling at a 50% duty cycle -> busy lasts 65536±2 cycles, and a second clear pulse mid-way does not extend it.
REQ-038 Bench SHALL cover: rst at clr_cnt=1000 with 3 FIFO entries -> next cycle busy=0, wr_ready=1, count=0, data=0.
